// File: rtl/x_buf_ctrl.sv
// x_buf_ctrl: sequencer for the 4-row x 8-byte X shift buffer and its MAC.
// A job runs LOAD (stream LOAD_BYTES bytes into the buffer), then for each
// output column COMPUTE (VEC_LEN shift/MAC cycles) and WRITE (result strobe),
// then a one-cycle DONE pulse.
// Optional feature: define X_BUF_CTRL_CYCLE_CNT_EN to add a saturating 16-bit
// busy-cycle counter output (cycle_cnt).
module x_buf_ctrl #(
    parameter int LOAD_BYTES = 32,
    parameter int VEC_LEN    = 8,
    parameter int NUM_COL    = 4,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              valid_input,
    output logic              input_load_en,
    output logic              X_shift,
    output logic              mac_en,
    output logic              mac_clr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              result_valid,
    output logic [1:0]        result_col,
    output logic              busy,
    output logic              done
`ifdef X_BUF_CTRL_CYCLE_CNT_EN
    ,
    output logic [15:0]       cycle_cnt
`endif
);

    localparam int LOAD_W = $clog2(LOAD_BYTES);
    localparam int ELEM_W = $clog2(VEC_LEN);

    localparam logic [LOAD_W-1:0] LAST_BYTE = LOAD_W'(LOAD_BYTES - 1);
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(VEC_LEN - 1);
    localparam logic [1:0]        LAST_COL  = 2'(NUM_COL - 1);
    localparam logic [ADDR_W-1:0] VEC_LEN_A = ADDR_W'(VEC_LEN);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        WRITE,
        DONE
    } state_t;

    state_t              state;
    logic [LOAD_W-1:0]   load_cnt;
    logic [ELEM_W-1:0]   elem;
    logic [1:0]          col;
    logic [ADDR_W-1:0]   col_base;

    // Coefficient base address of the current column.
    assign col_base = ADDR_W'(col) * VEC_LEN_A;

    // Job sequencer; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        // NOTE: state and outputs are flops, so every assignment here is
        // non-blocking; blocking would make later lines see the new value.
        if (rst) begin
            state         <= IDLE;
            load_cnt      <= '0;
            elem          <= '0;
            col           <= '0;
            input_load_en <= 1'b0;
            X_shift       <= 1'b0;
            mac_en        <= 1'b0;
            mac_clr       <= 1'b0;
            rom_addr      <= '0;
            result_valid  <= 1'b0;
            result_col    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            // Single-cycle strobes and compute-only buses fall to 0 unless
            // the next state sets them.
            X_shift      <= 1'b0;
            mac_en       <= 1'b0;
            mac_clr      <= 1'b0;
            rom_addr     <= '0;
            result_valid <= 1'b0;
            result_col   <= '0;
            done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= LOAD;
                        load_cnt      <= '0;
                        elem          <= '0;
                        col           <= '0;
                        input_load_en <= 1'b1;
                        busy          <= 1'b1;
                    end
                end

                LOAD: begin
                    if (valid_input) begin
                        if (load_cnt == LAST_BYTE) begin
                            load_cnt      <= '0;
                            state         <= COMPUTE;
                            input_load_en <= 1'b0;
                            X_shift       <= 1'b1;
                            mac_en        <= 1'b1;
                            mac_clr       <= 1'b1;
                            rom_addr      <= col_base;
                        end else begin
                            load_cnt <= load_cnt + LOAD_W'(1);
                        end
                    end
                end

                COMPUTE: begin
                    if (elem == LAST_ELEM) begin
                        elem         <= '0;
                        state        <= WRITE;
                        result_valid <= 1'b1;
                        result_col   <= col;
                    end else begin
                        elem     <= elem + ELEM_W'(1);
                        X_shift  <= 1'b1;
                        mac_en   <= 1'b1;
                        rom_addr <= col_base + ADDR_W'(elem) + ADDR_W'(1);
                    end
                end

                WRITE: begin
                    if (col < LAST_COL) begin
                        col      <= col + 2'd1;
                        state    <= COMPUTE;
                        X_shift  <= 1'b1;
                        mac_en   <= 1'b1;
                        mac_clr  <= 1'b1;
                        rom_addr <= col_base + VEC_LEN_A;
                    end else begin
                        col   <= '0;
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state         <= IDLE;
                    input_load_en <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

`ifdef X_BUF_CTRL_CYCLE_CNT_EN
    // Busy-cycle counter: cleared on accepted start, saturates, holds in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (state == IDLE && start) begin
            cycle_cnt <= '0;
        end else if (busy && cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_x_buf_ctrl.sv
// tb_x_buf_ctrl: self-checking bench for x_buf_ctrl. Expected outputs come
// from a cycle-indexed job timeline computed with plain arithmetic.
module tb_x_buf_ctrl;

    localparam int LOAD_BYTES = 32;
    localparam int VEC_LEN    = 8;
    localparam int NUM_COL    = 4;
    localparam int ADDR_W     = 5;
    localparam int COL_CYC    = VEC_LEN + 1;
    localparam int PAT_LEN    = 1024;

    logic              clk;
    logic              rst;
    logic              start;
    logic              valid_input;
    logic              input_load_en;
    logic              X_shift;
    logic              mac_en;
    logic              mac_clr;
    logic [ADDR_W-1:0] rom_addr;
    logic              result_valid;
    logic [1:0]        result_col;
    logic              busy;
    logic              done;
`ifdef X_BUF_CTRL_CYCLE_CNT_EN
    logic [15:0]       cycle_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cc_hold = 0;
    bit vpat [PAT_LEN];
    bit spat [PAT_LEN];

    typedef struct packed {
        logic              le;
        logic              sh;
        logic              me;
        logic              mc;
        logic [ADDR_W-1:0] addr;
        logic              rv;
        logic [1:0]        rc;
        logic              busy;
        logic              done;
    } outs_t;

    x_buf_ctrl #(
        .LOAD_BYTES(LOAD_BYTES),
        .VEC_LEN   (VEC_LEN),
        .NUM_COL   (NUM_COL),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .valid_input  (valid_input),
        .input_load_en(input_load_en),
        .X_shift      (X_shift),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .rom_addr     (rom_addr),
        .result_valid (result_valid),
        .result_col   (result_col),
        .busy         (busy),
        .done         (done)
`ifdef X_BUF_CTRL_CYCLE_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.le   = input_load_en;
        o.sh   = X_shift;
        o.me   = mac_en;
        o.mc   = mac_clr;
        o.addr = rom_addr;
        o.rv   = result_valid;
        o.rc   = result_col;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    // Expected outputs in cycle t of a job whose start is sampled at the end
    // of cycle 0 and whose last byte is accepted in cycle l.
    function automatic outs_t model(input int t, input int l);
        outs_t o;
        int k;
        o = '0;
        if (t >= 1 && t <= l) begin
            o.le   = 1'b1;
            o.busy = 1'b1;
        end else if (t > l) begin
            k = t - l - 1;
            if (k < NUM_COL * COL_CYC) begin
                o.busy = 1'b1;
                if (k % COL_CYC < VEC_LEN) begin
                    o.sh   = 1'b1;
                    o.me   = 1'b1;
                    o.mc   = (k % COL_CYC == 0);
                    o.addr = ADDR_W'((k / COL_CYC) * VEC_LEN + k % COL_CYC);
                end else begin
                    o.rv = 1'b1;
                    o.rc = 2'(k / COL_CYC);
                end
            end else if (k == NUM_COL * COL_CYC) begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic check_cc(input string tag, input int exp);
`ifdef X_BUF_CTRL_CYCLE_CNT_EN
        check(tag, 32'(cycle_cnt), 32'(exp));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            valid_input = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle outputs", 32'(sample()), 32'h0);
            check_cc("idle cycle_cnt hold", exp_cc_hold);
        end
    endtask

    // mode 0: continuous valid, 1: toggle 1,0 from cycle 1, 2: random gaps.
    task automatic run_job(input int mode, input bit stray, input bit do_abort);
        int l;
        int n;
        int abort_at;
        int last_t;
        int shifts;
        int dones;
        int addrs[$];
        int clr_addrs[$];
        outs_t got;
        outs_t exp;

        for (int i = 0; i < PAT_LEN; i++) begin
            if (mode == 0)      vpat[i] = 1'b1;
            else if (mode == 1) vpat[i] = (i % 2 == 1);
            else                vpat[i] = (i > 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
            spat[i] = stray && (i > 0) && ($urandom_range(0, 5) == 0);
        end
        n = 0;
        l = 1;
        while (l < PAT_LEN) begin
            if (vpat[l]) n++;
            if (n == LOAD_BYTES) break;
            l++;
        end
        abort_at = do_abort ? l + 1 + 2 * COL_CYC + 3 : -1;
        last_t   = l + NUM_COL * COL_CYC + 1;
        shifts   = 0;
        dones    = 0;

        for (int t = 0; t <= last_t; t++) begin
            @(posedge clk); #1;
            start       = (t == 0) ? 1'b1 : spat[t];
            valid_input = vpat[t];
            rst         = (t == abort_at);
            @(negedge clk);
            got = sample();
            exp = model(t, l);
            check($sformatf("outs mode=%0d t=%0d", mode, t), 32'(got), 32'(exp));
            if (t == 0) check_cc("cycle_cnt before start", exp_cc_hold);
            else        check_cc($sformatf("cycle_cnt t=%0d", t), t - 1);
            if (got.sh) begin
                shifts++;
                addrs.push_back(int'(got.addr));
                if (got.mc) clr_addrs.push_back(int'(got.addr));
            end
            if (got.done) dones++;
            if (t == abort_at) begin
                @(posedge clk); #1;
                rst         = 1'b0;
                start       = 1'b0;
                valid_input = 1'b1;
                @(negedge clk);
                check("outputs after mid-job reset", 32'(sample()), 32'h0);
                check_cc("cycle_cnt after reset", 0);
                exp_cc_hold = 0;
                return;
            end
        end
        start = 1'b0;
        exp_cc_hold = last_t;

        check($sformatf("shift count mode=%0d", mode), 32'(shifts), 32'(NUM_COL * VEC_LEN));
        check($sformatf("done count mode=%0d", mode), 32'(dones), 32'd1);
        check("rom_addr count", 32'(addrs.size()), 32'(NUM_COL * VEC_LEN));
        for (int i = 0; i < addrs.size(); i++)
            check($sformatf("rom_addr seq %0d", i), 32'(addrs[i]), 32'(i));
        check("mac_clr count", 32'(clr_addrs.size()), 32'(NUM_COL));
        for (int i = 0; i < clr_addrs.size(); i++)
            check($sformatf("mac_clr addr %0d", i), 32'(clr_addrs[i]), 32'(i * VEC_LEN));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        valid_input = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("outputs in reset", 32'(sample()), 32'h0);
        check_cc("cycle_cnt in reset", 0);
        @(posedge clk); #1;
        rst = 1'b0;

        idle(2);
        run_job(0, 1'b0, 1'b0);           // continuous valid: done at cycle 69
        idle(3);
        run_job(1, 1'b0, 1'b0);           // toggling valid: last accept cycle 63
        idle(1);
        run_job(0, 1'b1, 1'b0);           // stray starts during the job
        run_job(2, 1'b1, 1'b0);           // start on the cycle after done
        idle(2);
        run_job(0, 1'b0, 1'b1);           // reset at column 2, elem 3
        run_job(0, 1'b0, 1'b0);           // full timing reproduced
        for (int j = 0; j < 3; j++) begin
            run_job(2, 1'b1, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(1);

`ifdef X_BUF_CTRL_CYCLE_CNT_EN
        begin
            int seen;
            @(posedge clk); #1;
            start       = 1'b1;
            valid_input = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (65600) @(posedge clk);
            @(negedge clk);
            check("stall still loading", 32'(input_load_en), 32'd1);
            check("cycle_cnt saturated in stall", 32'(cycle_cnt), 32'hFFFF);
            #1 valid_input = 1'b1;
            seen = 0;
            for (int i = 0; i < 200 && seen == 0; i++) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            check("done after stall", 32'(seen), 32'd1);
            @(negedge clk);
            check("busy low after stall job", 32'(busy), 32'd0);
            check("cycle_cnt holds saturated", 32'(cycle_cnt), 32'hFFFF);
            valid_input = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
